// File: rtl/rob_pkg.sv
// Shared sizing and entry layout for the dual-issue reorder buffer.
package rob_pkg;

  localparam int TAG_W  = 5;
  localparam int DEPTH  = 32;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic              regwrite;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] data;
  } rob_entry_t;

  function automatic logic [TAG_W-1:0] tag_inc(input logic [TAG_W-1:0] t);
    return t + {{(TAG_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/rob_ptr_ctrl.sv
// Head/tail/occupancy bookkeeping for the reorder buffer, plus allocation
// gating and the conservative full flag.
module rob_ptr_ctrl
  import rob_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_stall,
  input  logic             i_alloc1,
  input  logic             i_alloc2,
  input  logic             i_r1,
  input  logic             i_r2,
  output logic             o_a1,
  output logic             o_a2,
  output logic [TAG_W-1:0] o_head,
  output logic [TAG_W-1:0] o_tail,
  output logic [TAG_W-1:0] o_tag1,
  output logic [TAG_W-1:0] o_tag2,
  output logic             o_full
);

  localparam logic [TAG_W:0] DEPTH_C = DEPTH[TAG_W:0];
  localparam logic [TAG_W:0] TWO_C   = {{(TAG_W-1){1'b0}}, 2'b10};

  logic [TAG_W-1:0] r_head;
  logic [TAG_W-1:0] r_tail;
  logic [TAG_W:0]   r_count;
  logic [TAG_W:0]   w_free;
  logic [TAG_W:0]   w_add;
  logic [TAG_W:0]   w_sub;

  // Full uses registered occupancy only, so a slot freed this cycle is not reused until next cycle.
  assign w_free = DEPTH_C - r_count;
  assign o_full = (w_free < TWO_C);

  assign o_a1 = i_alloc1 & ~i_stall & ~o_full;
  assign o_a2 = i_alloc2 & ~i_stall & ~o_full;

  assign o_tag1 = r_tail;
  assign o_tag2 = i_alloc1 ? tag_inc(r_tail) : r_tail;
  assign o_head = r_head;
  assign o_tail = r_tail;

  assign w_add = {{TAG_W{1'b0}}, o_a1} + {{TAG_W{1'b0}}, o_a2};
  assign w_sub = {{TAG_W{1'b0}}, i_r1} + {{TAG_W{1'b0}}, i_r2};

  // Pointer and occupancy registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_head  <= {TAG_W{1'b0}};
      r_tail  <= {TAG_W{1'b0}};
      r_count <= {(TAG_W+1){1'b0}};
    end else begin
      r_head  <= r_head + w_sub[TAG_W-1:0];
      r_tail  <= r_tail + w_add[TAG_W-1:0];
      r_count <= r_count + w_add - w_sub;
    end
  end

endmodule

// File: rtl/rob_buffer.sv
// Dual-issue circular reorder buffer: hands out tags at dispatch, captures
// four writeback ports, serves operand reads and retires up to two in order.
module rob_buffer
  import rob_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              alloc1,
  input  logic              alloc2,
  input  logic              RegWrite1,
  input  logic              RegWrite2,
  input  logic [REG_W-1:0]  DestReg1,
  input  logic [REG_W-1:0]  DestReg2,
  output logic [TAG_W-1:0]  tag1,
  output logic [TAG_W-1:0]  tag2,
  output logic              full,
  input  logic              alu1_wr,
  input  logic              alu2_wr,
  input  logic              ld1_wr,
  input  logic              ld2_wr,
  input  logic [TAG_W-1:0]  alu1_res_tag,
  input  logic [TAG_W-1:0]  alu2_res_tag,
  input  logic [TAG_W-1:0]  ld1_res_tag,
  input  logic [TAG_W-1:0]  ld2_res_tag,
  input  logic [DATA_W-1:0] alu1_res,
  input  logic [DATA_W-1:0] alu2_res,
  input  logic [DATA_W-1:0] ld1_res,
  input  logic [DATA_W-1:0] ld2_res,
  input  logic [TAG_W-1:0]  rd_tag0,
  input  logic [TAG_W-1:0]  rd_tag1,
  input  logic [TAG_W-1:0]  rd_tag2,
  input  logic [TAG_W-1:0]  rd_tag3,
  output logic [DATA_W-1:0] rd_data0,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic [DATA_W-1:0] rd_data3,
  output logic              commit1,
  output logic              commit2,
  output logic [REG_W-1:0]  commit1_addr,
  output logic [REG_W-1:0]  commit2_addr,
  output logic [TAG_W-1:0]  commit1_tag,
  output logic [TAG_W-1:0]  commit2_tag,
  output logic [DATA_W-1:0] commit1_data,
  output logic [DATA_W-1:0] commit2_data
);

  rob_entry_t       r_rob [DEPTH];
  logic [TAG_W-1:0] w_head;
  logic [TAG_W-1:0] w_head1;
  logic [TAG_W-1:0] w_tail;
  logic             w_a1;
  logic             w_a2;
  logic             w_r1;
  logic             w_r2;

  rob_ptr_ctrl u_ptr (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_stall  (stall),
    .i_alloc1 (alloc1),
    .i_alloc2 (alloc2),
    .i_r1     (w_r1),
    .i_r2     (w_r2),
    .o_a1     (w_a1),
    .o_a2     (w_a2),
    .o_head   (w_head),
    .o_tail   (w_tail),
    .o_tag1   (tag1),
    .o_tag2   (tag2),
    .o_full   (full)
  );

  assign w_head1 = tag_inc(w_head);
  assign w_r1    = r_rob[w_head].valid & r_rob[w_head].done;
  assign w_r2    = w_r1 & r_rob[w_head1].valid & r_rob[w_head1].done;

  // Non-register-writing entries still retire; they just never raise commitN.
  assign commit1      = w_r1 & r_rob[w_head].regwrite;
  assign commit2      = w_r2 & r_rob[w_head1].regwrite;
  assign commit1_addr = w_r1 ? r_rob[w_head].dest  : {REG_W{1'b0}};
  assign commit2_addr = w_r2 ? r_rob[w_head1].dest : {REG_W{1'b0}};
  assign commit1_tag  = w_r1 ? w_head              : {TAG_W{1'b0}};
  assign commit2_tag  = w_r2 ? w_head1             : {TAG_W{1'b0}};
  assign commit1_data = w_r1 ? r_rob[w_head].data  : {DATA_W{1'b0}};
  assign commit2_data = w_r2 ? r_rob[w_head1].data : {DATA_W{1'b0}};

  assign rd_data0 = r_rob[rd_tag0].data;
  assign rd_data1 = r_rob[rd_tag1].data;
  assign rd_data2 = r_rob[rd_tag2].data;
  assign rd_data3 = r_rob[rd_tag3].data;

  // Entry array: writeback (later ports win), then retirement clears, then allocation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_rob[i] <= '{valid: 1'b0, done: 1'b0, regwrite: 1'b0,
                      dest: {REG_W{1'b0}}, data: {DATA_W{1'b0}}};
      end
    end else begin
      if (alu1_wr && r_rob[alu1_res_tag].valid) begin
        r_rob[alu1_res_tag].done <= 1'b1;
        r_rob[alu1_res_tag].data <= alu1_res;
      end
      if (alu2_wr && r_rob[alu2_res_tag].valid) begin
        r_rob[alu2_res_tag].done <= 1'b1;
        r_rob[alu2_res_tag].data <= alu2_res;
      end
      if (ld1_wr && r_rob[ld1_res_tag].valid) begin
        r_rob[ld1_res_tag].done <= 1'b1;
        r_rob[ld1_res_tag].data <= ld1_res;
      end
      if (ld2_wr && r_rob[ld2_res_tag].valid) begin
        r_rob[ld2_res_tag].done <= 1'b1;
        r_rob[ld2_res_tag].data <= ld2_res;
      end
      if (w_r1) begin
        r_rob[w_head].valid <= 1'b0;
        r_rob[w_head].done  <= 1'b0;
      end
      if (w_r2) begin
        r_rob[w_head1].valid <= 1'b0;
        r_rob[w_head1].done  <= 1'b0;
      end
      if (w_a1) begin
        r_rob[tag1].valid    <= 1'b1;
        r_rob[tag1].done     <= 1'b0;
        r_rob[tag1].regwrite <= RegWrite1;
        r_rob[tag1].dest     <= DestReg1;
      end
      if (w_a2) begin
        r_rob[tag2].valid    <= 1'b1;
        r_rob[tag2].done     <= 1'b0;
        r_rob[tag2].regwrite <= RegWrite2;
        r_rob[tag2].dest     <= DestReg2;
      end
    end
  end

endmodule

// File: tb/tb_rob_buffer.sv
// Scoreboard bench for rob_buffer: allocations push tags into an in-order
// queue, writebacks mark them done, and commit outputs are compared each cycle.
module tb_rob_buffer;
  import rob_pkg::*;

  logic clk = 1'b0;
  logic rst, stall, alloc1, alloc2, RegWrite1, RegWrite2;
  logic [4:0] DestReg1, DestReg2;
  logic [4:0] tag1, tag2;
  logic full;
  logic alu1_wr, alu2_wr, ld1_wr, ld2_wr;
  logic [4:0] alu1_res_tag, alu2_res_tag, ld1_res_tag, ld2_res_tag;
  logic [31:0] alu1_res, alu2_res, ld1_res, ld2_res;
  logic [4:0] rd_tag0, rd_tag1, rd_tag2, rd_tag3;
  logic [31:0] rd_data0, rd_data1, rd_data2, rd_data3;
  logic commit1, commit2;
  logic [4:0] commit1_addr, commit2_addr, commit1_tag, commit2_tag;
  logic [31:0] commit1_data, commit2_data;

  int n_vec = 0;
  int n_err = 0;

  // scoreboard state
  int          q[$];
  bit          m_valid [32];
  bit          m_done  [32];
  bit          m_rw    [32];
  logic [4:0]  m_dest  [32];
  logic [31:0] m_data  [32];
  logic [4:0]  m_tail;

  bit          er1, er2, pr1, pr2, mfull;
  logic [4:0]  h0, h1;
  logic        e_c1, e_c2;
  logic [4:0]  e_t1, e_t2, e_a1, e_a2;
  logic [31:0] e_d1, e_d2;

  rob_buffer dut (
    .clk(clk), .rst(rst), .stall(stall), .alloc1(alloc1), .alloc2(alloc2),
    .RegWrite1(RegWrite1), .RegWrite2(RegWrite2), .DestReg1(DestReg1), .DestReg2(DestReg2),
    .tag1(tag1), .tag2(tag2), .full(full),
    .alu1_wr(alu1_wr), .alu2_wr(alu2_wr), .ld1_wr(ld1_wr), .ld2_wr(ld2_wr),
    .alu1_res_tag(alu1_res_tag), .alu2_res_tag(alu2_res_tag),
    .ld1_res_tag(ld1_res_tag), .ld2_res_tag(ld2_res_tag),
    .alu1_res(alu1_res), .alu2_res(alu2_res), .ld1_res(ld1_res), .ld2_res(ld2_res),
    .rd_tag0(rd_tag0), .rd_tag1(rd_tag1), .rd_tag2(rd_tag2), .rd_tag3(rd_tag3),
    .rd_data0(rd_data0), .rd_data1(rd_data1), .rd_data2(rd_data2), .rd_data3(rd_data3),
    .commit1(commit1), .commit2(commit2),
    .commit1_addr(commit1_addr), .commit2_addr(commit2_addr),
    .commit1_tag(commit1_tag), .commit2_tag(commit2_tag),
    .commit1_data(commit1_data), .commit2_data(commit2_data)
  );

  always #5 clk = ~clk;

  // Compare the commit stream and full flag against the queue on every falling edge.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      er1 = (q.size() > 0) && m_done[q[0]];
      er2 = er1 && (q.size() > 1) && m_done[q[1]];
      h0 = (q.size() > 0) ? q[0][4:0] : 5'd0;
      h1 = (q.size() > 1) ? q[1][4:0] : 5'd0;
      e_c1 = er1 && m_rw[h0];
      e_c2 = er2 && m_rw[h1];
      e_t1 = er1 ? h0 : 5'd0;
      e_t2 = er2 ? h1 : 5'd0;
      e_a1 = er1 ? m_dest[h0] : 5'd0;
      e_a2 = er2 ? m_dest[h1] : 5'd0;
      e_d1 = er1 ? m_data[h0] : 32'd0;
      e_d2 = er2 ? m_data[h1] : 32'd0;
      n_vec++;
      if (full !== (q.size() >= 31)) begin
        n_err++; $display("FAIL sb_full got %0b exp %0b", full, (q.size() >= 31));
      end
      n_vec++;
      if ({commit1, commit2} !== {e_c1, e_c2}) begin
        n_err++; $display("FAIL sb_commit got %b exp %b", {commit1, commit2}, {e_c1, e_c2});
      end
      n_vec++;
      if ({commit1_tag, commit2_tag} !== {e_t1, e_t2}) begin
        n_err++; $display("FAIL sb_tag got %0d/%0d exp %0d/%0d", commit1_tag, commit2_tag, e_t1, e_t2);
      end
      n_vec++;
      if ({commit1_addr, commit2_addr} !== {e_a1, e_a2}) begin
        n_err++; $display("FAIL sb_addr got %0d/%0d exp %0d/%0d", commit1_addr, commit2_addr, e_a1, e_a2);
      end
      n_vec++;
      if ({commit1_data, commit2_data} !== {e_d1, e_d2}) begin
        n_err++; $display("FAIL sb_data got %h/%h exp %h/%h", commit1_data, commit2_data, e_d1, e_d2);
      end
    end
  end

  // Advance the scoreboard on each rising edge from the inputs the bench applied.
  always @(posedge clk) begin
    if (rst === 1'b1) begin
      q.delete();
      for (int i = 0; i < 32; i++) begin
        m_valid[i] = 1'b0; m_done[i] = 1'b0; m_data[i] = 32'd0;
      end
      m_tail = 5'd0;
    end else begin
      pr1 = (q.size() > 0) && m_done[q[0]];
      pr2 = pr1 && (q.size() > 1) && m_done[q[1]];
      mfull = (q.size() >= 31);
      if (alu1_wr && m_valid[alu1_res_tag]) begin m_done[alu1_res_tag] = 1'b1; m_data[alu1_res_tag] = alu1_res; end
      if (alu2_wr && m_valid[alu2_res_tag]) begin m_done[alu2_res_tag] = 1'b1; m_data[alu2_res_tag] = alu2_res; end
      if (ld1_wr && m_valid[ld1_res_tag]) begin m_done[ld1_res_tag] = 1'b1; m_data[ld1_res_tag] = ld1_res; end
      if (ld2_wr && m_valid[ld2_res_tag]) begin m_done[ld2_res_tag] = 1'b1; m_data[ld2_res_tag] = ld2_res; end
      if (pr1) begin m_valid[q[0]] = 1'b0; m_done[q[0]] = 1'b0; void'(q.pop_front()); end
      if (pr2) begin m_valid[q[0]] = 1'b0; m_done[q[0]] = 1'b0; void'(q.pop_front()); end
      if (!stall && !mfull) begin
        if (alloc1) begin
          m_valid[m_tail] = 1'b1; m_done[m_tail] = 1'b0;
          m_rw[m_tail] = RegWrite1; m_dest[m_tail] = DestReg1;
          q.push_back(int'(m_tail)); m_tail = m_tail + 5'd1;
        end
        if (alloc2) begin
          m_valid[m_tail] = 1'b1; m_done[m_tail] = 1'b0;
          m_rw[m_tail] = RegWrite2; m_dest[m_tail] = DestReg2;
          q.push_back(int'(m_tail)); m_tail = m_tail + 5'd1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr_wb();
    alu1_wr = 1'b0; alu2_wr = 1'b0; ld1_wr = 1'b0; ld2_wr = 1'b0;
  endtask

  task automatic alloc_n(input int n);
    RegWrite1 = 1'b1; RegWrite2 = 1'b1;
    for (int i = 0; i < n / 2; i++) begin
      alloc1 = 1'b1; alloc2 = 1'b1;
      DestReg1 = 5'($urandom_range(31)); DestReg2 = 5'($urandom_range(31));
      tick();
    end
    if (n % 2 == 1) begin
      alloc1 = 1'b1; alloc2 = 1'b0; DestReg1 = 5'($urandom_range(31));
      tick();
    end
    alloc1 = 1'b0; alloc2 = 1'b0;
  endtask

  task automatic wb_and_drain();
    int tags[$];
    tags = q;
    for (int i = 0; i < tags.size(); i += 4) begin
      clr_wb();
      alu1_wr = 1'b1; alu1_res_tag = 5'(tags[i]); alu1_res = $urandom;
      if (i + 1 < tags.size()) begin alu2_wr = 1'b1; alu2_res_tag = 5'(tags[i+1]); alu2_res = $urandom; end
      if (i + 2 < tags.size()) begin ld1_wr = 1'b1; ld1_res_tag = 5'(tags[i+2]); ld1_res = $urandom; end
      if (i + 3 < tags.size()) begin ld2_wr = 1'b1; ld2_res_tag = 5'(tags[i+3]); ld2_res = $urandom; end
      tick();
    end
    clr_wb();
    for (int c = 0; c < 100 && q.size() > 0; c++) tick();
    n_vec++;
    if (q.size() != 0) begin n_err++; $display("FAIL drain_timeout got %0d left exp 0", q.size()); end
  endtask

  task automatic test_reset();
    rst = 1'b1; alloc1 = 1'b1; #1;
    n_vec++; if (tag1 !== 5'd0) begin n_err++; $display("FAIL rst_tag1 got %0d exp 0", tag1); end
    n_vec++; if (tag2 !== 5'd1) begin n_err++; $display("FAIL rst_tag2 got %0d exp 1", tag2); end
    n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL rst_full got %0b exp 0", full); end
    n_vec++; if ({commit1, commit2} !== 2'b00) begin n_err++; $display("FAIL rst_commit got %b exp 00", {commit1, commit2}); end
    n_vec++; if (rd_data0 !== 32'd0) begin n_err++; $display("FAIL rst_rd got %h exp 0", rd_data0); end
    tick(); tick();
    rst = 1'b0; alloc1 = 1'b0;
  endtask

  task automatic test_dual_alloc();
    alloc1 = 1'b1; alloc2 = 1'b1; RegWrite1 = 1'b1; RegWrite2 = 1'b1;
    DestReg1 = 5'd3; DestReg2 = 5'd4; #1;
    n_vec++; if ({tag1, tag2} !== {5'd0, 5'd1}) begin n_err++; $display("FAIL alloc_tags got %0d/%0d exp 0/1", tag1, tag2); end
    tick();
    alloc1 = 1'b0; alloc2 = 1'b0; #1;
    n_vec++; if ({tag1, tag2} !== {5'd2, 5'd2}) begin n_err++; $display("FAIL alloc_next got %0d/%0d exp 2/2", tag1, tag2); end
  endtask

  task automatic test_out_of_order_wb();
    alu1_wr = 1'b1; alu1_res_tag = 5'd1; alu1_res = 32'hAA; rd_tag0 = 5'd1;
    tick();
    clr_wb(); alu2_wr = 1'b1; alu2_res_tag = 5'd0; alu2_res = 32'h55; #1;
    n_vec++; if (commit1 !== 1'b0) begin n_err++; $display("FAIL ooo_wait got %0b exp 0", commit1); end
    n_vec++; if (rd_data0 !== 32'hAA) begin n_err++; $display("FAIL ooo_rd got %h exp aa", rd_data0); end
    tick();
    clr_wb(); #1;
    n_vec++;
    if ({commit1, commit1_addr, commit1_tag, commit1_data} !== {1'b1, 5'd3, 5'd0, 32'h55}) begin
      n_err++; $display("FAIL ooo_c1 got %0b/%0d/%0d/%h exp 1/3/0/55", commit1, commit1_addr, commit1_tag, commit1_data);
    end
    n_vec++;
    if ({commit2, commit2_addr, commit2_tag, commit2_data} !== {1'b1, 5'd4, 5'd1, 32'hAA}) begin
      n_err++; $display("FAIL ooo_c2 got %0b/%0d/%0d/%h exp 1/4/1/aa", commit2, commit2_addr, commit2_tag, commit2_data);
    end
    tick();
  endtask

  task automatic test_full();
    alloc_n(31); #1;
    n_vec++; if (full !== 1'b1) begin n_err++; $display("FAIL full_set got %0b exp 1", full); end
    n_vec++; if (tag1 !== 5'd1) begin n_err++; $display("FAIL full_tag got %0d exp 1", tag1); end
    alloc1 = 1'b1; tick(); alloc1 = 1'b0; #1;
    n_vec++; if (tag1 !== 5'd1) begin n_err++; $display("FAIL full_ignored got %0d exp 1", tag1); end
    wb_and_drain();
  endtask

  task automatic test_wrap();
    alloc_n(29);
    wb_and_drain();
    alloc1 = 1'b1; alloc2 = 1'b1; DestReg1 = 5'd7; DestReg2 = 5'd8; #1;
    n_vec++; if ({tag1, tag2} !== {5'd30, 5'd31}) begin n_err++; $display("FAIL wrap_tags got %0d/%0d exp 30/31", tag1, tag2); end
    tick();
    alloc2 = 1'b0; DestReg1 = 5'd10; #1;
    n_vec++; if (tag1 !== 5'd0) begin n_err++; $display("FAIL wrap_tag0 got %0d exp 0", tag1); end
    tick();
    alloc1 = 1'b0;
    alu1_wr = 1'b1; alu1_res_tag = 5'd30; alu1_res = 32'h30;
    alu2_wr = 1'b1; alu2_res_tag = 5'd31; alu2_res = 32'h31;
    ld1_wr = 1'b1; ld1_res_tag = 5'd0; ld1_res = 32'h100;
    tick(); clr_wb(); #1;
    n_vec++;
    if ({commit1_tag, commit2_tag, commit1_addr, commit2_addr} !== {5'd30, 5'd31, 5'd7, 5'd8}) begin
      n_err++; $display("FAIL wrap_pair got %0d/%0d exp 30/31", commit1_tag, commit2_tag);
    end
    tick(); #1;
    n_vec++;
    if ({commit1, commit1_tag, commit1_data, commit2} !== {1'b1, 5'd0, 32'h100, 1'b0}) begin
      n_err++; $display("FAIL wrap_zero got %0b/%0d/%h/%0b exp 1/0/100/0", commit1, commit1_tag, commit1_data, commit2);
    end
    tick();
    n_vec++; if (tag1 !== 5'd1) begin n_err++; $display("FAIL wrap_tail got %0d exp 1", tag1); end
  endtask

  task automatic test_silent_retire();
    alloc1 = 1'b1; alloc2 = 1'b1; RegWrite1 = 1'b0; RegWrite2 = 1'b1;
    DestReg1 = 5'd12; DestReg2 = 5'd9;
    tick();
    alloc1 = 1'b0; alloc2 = 1'b0;
    ld2_wr = 1'b1; ld2_res_tag = 5'd1; ld2_res = 32'hDEAD;
    tick();
    clr_wb(); alu1_wr = 1'b1; alu1_res_tag = 5'd2; alu1_res = 32'hBEEF; #1;
    n_vec++;
    if ({commit1, commit1_tag, commit2} !== {1'b0, 5'd1, 1'b0}) begin
      n_err++; $display("FAIL silent_head got %0b/%0d/%0b exp 0/1/0", commit1, commit1_tag, commit2);
    end
    tick();
    clr_wb(); #1;
    n_vec++;
    if ({commit1, commit1_tag, commit1_addr, commit1_data} !== {1'b1, 5'd2, 5'd9, 32'hBEEF}) begin
      n_err++; $display("FAIL silent_next got %0b/%0d/%0d/%h exp 1/2/9/beef", commit1, commit1_tag, commit1_addr, commit1_data);
    end
    tick();
  endtask

  task automatic test_mid_reset();
    alloc_n(5);
    alu1_wr = 1'b1; alu1_res_tag = 5'd3; alu1_res = 32'h1234;
    tick();
    clr_wb(); #1;
    n_vec++; if (commit1 !== 1'b1) begin n_err++; $display("FAIL mrst_pre got %0b exp 1", commit1); end
    rst = 1'b1; #1;
    n_vec++;
    if ({commit1, commit2, full, tag1, commit1_tag} !== {1'b0, 1'b0, 1'b0, 5'd0, 5'd0}) begin
      n_err++; $display("FAIL mrst_now got %b/%0d exp 000/0", {commit1, commit2, full}, tag1);
    end
    tick();
    rst = 1'b0;
    alu1_wr = 1'b1; alu1_res_tag = 5'd3; alu1_res = 32'h77; rd_tag0 = 5'd3;
    tick();
    clr_wb(); #1;
    n_vec++; if (rd_data0 !== 32'd0) begin n_err++; $display("FAIL mrst_stale got %h exp 0", rd_data0); end
    alloc1 = 1'b1; tick(); alloc1 = 1'b0; #1;
    n_vec++; if ({commit1, tag1} !== {1'b0, 5'd1}) begin n_err++; $display("FAIL mrst_alloc got %0b/%0d exp 0/1", commit1, tag1); end
    tick(); tick();
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; alloc1 = 1'b0; alloc2 = 1'b0;
    RegWrite1 = 1'b0; RegWrite2 = 1'b0; DestReg1 = 5'd0; DestReg2 = 5'd0;
    clr_wb();
    alu1_res_tag = 5'd0; alu2_res_tag = 5'd0; ld1_res_tag = 5'd0; ld2_res_tag = 5'd0;
    alu1_res = 32'd0; alu2_res = 32'd0; ld1_res = 32'd0; ld2_res = 32'd0;
    rd_tag0 = 5'd0; rd_tag1 = 5'd1; rd_tag2 = 5'd2; rd_tag3 = 5'd3;
    test_reset();
    test_dual_alloc();
    test_out_of_order_wb();
    test_full();
    test_wrap();
    test_silent_retire();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
